delta_decompressor: RTL and testbench
=====================================

Name: delta_decompressor

Overview:
- Offline/readback-side inverse of the delta compressor.
- Consumes trace-buffer lines in write order. Each line is a raw base vector or a packed delta word per lane.
- Reconstructs the original N-lane vector stream, one vector per accepted output beat.
- Sits between trace-buffer readout and the host/debug extraction path, with ready/valid on both sides.

Parameters:
- N, 8, number of lanes per vector.
- DATA_WIDTH, 32, bits per lane.
- DELTA_SLOTS, 4, delta slots packed per lane word.
- COMPRESSED, 0, value of comp_in that marks a delta-packed line; ~COMPRESSED marks a raw line.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  input line valid.
- ready_in  out  1  decompressor can accept a line this cycle.
- comp_in  in  1  line type flag (see COMPRESSED).
- vector_in  in  [DATA_WIDTH-1:0] x N  trace-buffer line.
- valid_out  out  1  reconstructed vector valid.
- ready_out  in  1  downstream accepts vector_out.
- vector_out  out  [DATA_WIDTH-1:0] x N  reconstructed vector.
- error  out  1  sticky protocol error.

Behaviour:
- Constants:
  - PRECISION = DATA_WIDTH/DELTA_SLOTS.
  - INV = 1 followed by (PRECISION-1) zeros.
  - NODATA = INV replicated DELTA_SLOTS times.
- Slot order: slot 0 = most significant PRECISION bits of each lane word (first delta written); slot DELTA_SLOTS-1 = least significant.
- Reconstruction rule:
  - cur = base - sext(delta), modulo 2^DATA_WIDTH.
  - delta is the signed PRECISION-bit slot value.
  - base is updated to cur after every emitted vector.
- States: NOBASE, IDLE, EXPAND. Output register is separate; out_free = !valid_out || ready_out.
- ready_in = out_free && state != EXPAND (combinational).
- Reset (any state, mid-expansion included):
  - state = NOBASE; valid_out = 0; vector_out = 0; error = 0; base and slot counter k = 0.
  - Takes effect at the edge where reset is sampled high.
- Raw line accepted (valid_in && ready_in && comp_in == ~COMPRESSED), from NOBASE or IDLE:
  - base <= vector_in.
  - valid_out = 1 and vector_out = vector_in at the next edge (latency 1).
  - state <= IDLE.
- Compressed line accepted in NOBASE: dropped; error <= 1; no output; stays NOBASE.
- Compressed line accepted in IDLE:
  - Latch line into entry register; k <= 0; state <= EXPAND.
  - No output on the accept edge.
- EXPAND, each edge with out_free:
  - If lane 0 slot k == INV: no emit; state <= IDLE (one bubble cycle).
  - Else: emit cur for all lanes (valid_out <= 1); base <= cur.
  - If k == DELTA_SLOTS-1: state <= IDLE; else k <= k+1.
  - First reconstructed vector appears on the 2nd edge after acceptance.
  - Throughput: 1 vector/cycle when ready_out is held high.
- Slot-validity consistency: if any lane's slot k is INV while lane 0's is not, or vice versa:
  - error <= 1.
  - Lane 0 decides emit/stop.
  - Lanes holding INV with lane 0 valid output base unchanged (delta treated as 0).
- A NODATA compressed line produces no output and no error; returns to IDLE after one EXPAND cycle.
- Backpressure: while valid_out && !ready_out, vector_out, valid_out, base, k and state all hold.
- valid_out clears on an edge where ready_out is high and no new vector is emitted.
- Lines with valid_in low are ignored. comp_in and vector_in are don't-care unless valid_in is high.
- error clears only on reset.

Decomposition:
- Package delta_pkg holds:
  - Functions deriving PRECISION, INV and NODATA from DATA_WIDTH/DELTA_SLOTS (shared with the compressor).
  - State enum {NOBASE, IDLE, EXPAND}.
  - sext_delta function.
- Sub-module delta_lane_reconstruct, one instance per lane, purely combinational:
  - Inputs: lane word, k, base.
  - Outputs: slot_is_inv, cur.
- Top level holds the FSM, entry/base/output registers and handshake.

Test Plan:
- Raw line with lanes 100..107, ready_out=1 → one beat next cycle, vector_out=100..107, error=0.
- Raw base 100 (all lanes), then compressed line 0x01FF0380 on all lanes → beats 99, 100, 97; one bubble; state IDLE; ready_in returns high.
- Base 100, compressed 0x02020202 → 98, 96, 94, 92 on consecutive cycles; no bubble; then accepts the next line.
- After reset, compressed 0x01020304 → no valid_out; error=1. Following raw 5 → outputs 5; error stays 1.
- Base 100, compressed 0x02020202, ready_out low for 3 cycles after the first beat:
  - vector_out stays 98; ready_in stays low.
  - Resume gives 96, 94, 92 with no loss or duplication.
- Reset asserted during EXPAND after beat 98:
  - valid_out=0 next edge.
  - A subsequent compressed line errors.
  - NODATA 0x80808080 after a raw base gives no output and error=0.

Source files
------------

// File: rtl/delta_pkg.sv
// Shared definitions for the delta trace compressor/decompressor pair.
// Slot geometry helpers, FSM state type and delta sign extension.
package delta_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {StNoBase, StIdle, StExpand} state_e;

  function automatic int unsigned precision(input int unsigned data_width,
                                            input int unsigned delta_slots);
    return data_width / delta_slots;
  endfunction

  // Slot value reserved as "no delta here": MSB set, rest zero.
  function automatic logic [MaxWidth-1:0] inv_slot(input int unsigned prec);
    logic [MaxWidth-1:0] res;
    res = '0;
    res[prec-1] = 1'b1;
    return res;
  endfunction

  function automatic logic [MaxWidth-1:0] nodata_word(input int unsigned data_width,
                                                      input int unsigned delta_slots);
    logic [MaxWidth-1:0] res;
    int unsigned prec;
    prec = precision(data_width, delta_slots);
    res = '0;
    for (int unsigned s = 0; s < delta_slots; s++) begin
      res = res | (inv_slot(prec) << (s * prec));
    end
    return res;
  endfunction

  function automatic logic [MaxWidth-1:0] sext_delta(input logic [MaxWidth-1:0] slot,
                                                     input int unsigned prec);
    logic [MaxWidth-1:0] res;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      res[i] = (i < prec) ? slot[i] : slot[prec-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/delta_lane_reconstruct.sv
// One lane of delta reconstruction: selects slot k of the packed lane word
// and applies it to the lane base. An INV slot leaves the base untouched.
module delta_lane_reconstruct
  import delta_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DELTA_SLOTS = 4,
  parameter int unsigned KW          = 2
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [KW-1:0]         k_i,
  input  logic [DATA_WIDTH-1:0] base_i,
  output logic                  slot_is_inv_o,
  output logic [DATA_WIDTH-1:0] cur_o
);

  localparam int unsigned Prec = precision(DATA_WIDTH, DELTA_SLOTS);
  localparam logic [Prec-1:0] Inv = Prec'(inv_slot(Prec));

  logic [Prec-1:0]       slots [DELTA_SLOTS];
  logic [Prec-1:0]       slot;
  logic [DATA_WIDTH-1:0] delta;

  // Slot 0 occupies the most significant bits of the word.
  for (genvar s = 0; s < DELTA_SLOTS; s++) begin : g_slot
    assign slots[s] = word_i[DATA_WIDTH-1-s*Prec -: Prec];
  end

  assign slot          = slots[k_i];
  assign delta         = DATA_WIDTH'(sext_delta(MaxWidth'(slot), Prec));
  assign slot_is_inv_o = (slot == Inv);
  assign cur_o         = slot_is_inv_o ? base_i : base_i - delta;

endmodule

// File: rtl/delta_decompressor.sv
// Rebuilds the N-lane vector stream from raw base lines and delta-packed
// lines read back from the trace buffer; ready/valid on both sides.
module delta_decompressor
  import delta_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DELTA_SLOTS = 4,
  parameter bit          COMPRESSED  = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic                          comp_in,
  input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
  output logic                          error
);

  localparam int unsigned KW = (DELTA_SLOTS > 1) ? $clog2(DELTA_SLOTS) : 1;
  localparam logic [KW-1:0] LastK = KW'(DELTA_SLOTS - 1);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  vec_t            base_q, base_d;
  vec_t            entry_q, entry_d;
  vec_t            vec_q, vec_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [N-1:0]    inv_vec;
  vec_t            cur_vec;
  logic            out_free;
  logic            accept;
  logic            is_comp;
  logic            lane_mismatch;

  for (genvar l = 0; l < N; l++) begin : g_lane
    delta_lane_reconstruct #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DELTA_SLOTS (DELTA_SLOTS),
      .KW          (KW)
    ) u_lane (
      .word_i        (entry_q[l]),
      .k_i           (k_q),
      .base_i        (base_q[l]),
      .slot_is_inv_o (inv_vec[l]),
      .cur_o         (cur_vec[l])
    );
  end

  assign out_free      = !valid_q || ready_out;
  assign ready_in      = out_free && (state_q != StExpand);
  assign accept        = valid_in && ready_in;
  assign is_comp       = (comp_in == COMPRESSED);
  // Every lane must agree with lane 0 on whether slot k carries a delta.
  assign lane_mismatch = (inv_vec != {N{inv_vec[0]}});

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    entry_d = entry_q;
    vec_d   = vec_q;
    err_d   = err_q;
    valid_d = valid_q && !ready_out;

    unique case (state_q)
      StNoBase, StIdle: begin
        if (accept) begin
          if (!is_comp) begin
            base_d  = vector_in;
            vec_d   = vector_in;
            valid_d = 1'b1;
            state_d = StIdle;
          end else if (state_q == StNoBase) begin
            err_d = 1'b1;
          end else begin
            entry_d = vector_in;
            k_d     = '0;
            state_d = StExpand;
          end
        end
      end
      StExpand: begin
        if (out_free) begin
          if (lane_mismatch) err_d = 1'b1;
          if (inv_vec[0]) begin
            state_d = StIdle;
          end else begin
            vec_d   = cur_vec;
            base_d  = cur_vec;
            valid_d = 1'b1;
            if (k_q == LastK) state_d = StIdle;
            else              k_d     = k_q + KW'(1);
          end
        end
      end
      default: state_d = StNoBase;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StNoBase;
      k_q     <= '0;
      base_q  <= '0;
      entry_q <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      entry_q <= entry_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign valid_out  = valid_q;
  assign vector_out = vec_q;
  assign error      = err_q;

endmodule

// File: tb/tb_delta_decompressor.sv
// Bench for delta_decompressor: table of line types with expected beat counts,
// a reference model feeding a scoreboard queue, and hand-written corner sequences.
module tb_delta_decompressor;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam bit COMPRESSED  = 1'b0;

  typedef logic [N-1:0][DW-1:0] vec_t;

  typedef struct {
    bit          comp;
    logic [31:0] word;
    int          beats;
    logic [31:0] last;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  logic valid_in;
  logic ready_in;
  logic comp_in;
  vec_t vector_in;
  logic valid_out;
  logic ready_out;
  vec_t vector_out;
  logic error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [31:0] last_lane0 = '0;

  vec_t exp_q[$];
  vec_t mbase;
  bit   mnobase;
  bit   merr;

  delta_decompressor #(
    .N           (N),
    .DATA_WIDTH  (DW),
    .DELTA_SLOTS (4),
    .COMPRESSED  (COMPRESSED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .comp_in    (comp_in),
    .vector_in  (vector_in),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .vector_out (vector_out),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic vec_t fill(input logic [31:0] w);
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = w;
    return v;
  endfunction

  // Scoreboard consumer: every accepted output beat is compared to the model.
  always @(negedge clk) begin
    if (!reset && valid_out && ready_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: got %h expected no beat", vector_out);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        if (vector_out !== e) begin
          errors++;
          $display("FAIL beat: got %h expected %h", vector_out, e);
        end
      end
      if (beat_cnt == 0) first_cyc = cyc;
      last_cyc   = cyc;
      beat_cnt   = beat_cnt + 1;
      last_lane0 = vector_out[0];
    end
  end

  task automatic model_line(input bit comp, input vec_t v);
    if (!comp) begin
      mbase   = v;
      mnobase = 1'b0;
      exp_q.push_back(v);
    end else if (mnobase) begin
      merr = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] s0;
        logic [7:0] s;
        s0 = v[0][31-8*k -: 8];
        for (int l = 0; l < N; l++) begin
          s = v[l][31-8*k -: 8];
          if ((s == 8'h80) != (s0 == 8'h80)) merr = 1'b1;
        end
        if (s0 == 8'h80) break;
        for (int l = 0; l < N; l++) begin
          s = v[l][31-8*k -: 8];
          if (s != 8'h80) mbase[l] = mbase[l] - {{24{s[7]}}, s};
        end
        exp_q.push_back(mbase);
      end
    end
  endtask

  task automatic send(input bit comp, input vec_t v);
    int t = 0;
    @(negedge clk);
    valid_in  = 1'b1;
    comp_in   = comp ? COMPRESSED : ~COMPRESSED;
    vector_in = v;
    while (!ready_in && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_in=0 expected 1 within 100 cycles");
    end else begin
      model_line(comp, v);
    end
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    vector_in = '0;
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mbase   = '0;
    mnobase = 1'b1;
    merr    = 1'b0;
    beat_cnt = 0;
  endtask

  row_t rows[8];
  vec_t v;

  initial begin
    rows[0] = '{comp: 1'b0, word: 32'd100,       beats: 1, last: 32'd100};
    rows[1] = '{comp: 1'b1, word: 32'h01FF0380,  beats: 3, last: 32'd97};
    rows[2] = '{comp: 1'b0, word: 32'd100,       beats: 1, last: 32'd100};
    rows[3] = '{comp: 1'b1, word: 32'h02020202,  beats: 4, last: 32'd92};
    rows[4] = '{comp: 1'b1, word: 32'h80808080,  beats: 0, last: 32'd92};
    rows[5] = '{comp: 1'b0, word: 32'h7FFFFFFF,  beats: 1, last: 32'h7FFFFFFF};
    rows[6] = '{comp: 1'b1, word: 32'hFF7F0101,  beats: 4, last: 32'h7FFFFF7F};
    rows[7] = '{comp: 1'b1, word: 32'h00000000,  beats: 4, last: 32'h7FFFFF7F};

    reset     = 1'b1;
    valid_in  = 1'b0;
    comp_in   = 1'b0;
    vector_in = '0;
    ready_out = 1'b1;
    do_reset();

    chk("reset_valid_out", 64'(valid_out), 64'd0);
    chk("reset_vector_out", 64'(vector_out[0]), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_ready_in", 64'(ready_in), 64'd1);

    // Raw line with distinct lanes, latency 1.
    for (int l = 0; l < N; l++) v[l] = 32'(100 + l);
    send(1'b0, v);
    chk("raw_latency_valid", 64'(valid_out), 64'd1);
    chk("raw_lane7", 64'(vector_out[7]), 64'd107);
    drain();

    // Table of line types on all lanes.
    for (int i = 0; i < 8; i++) begin
      beat_cnt = 0;
      send(rows[i].comp, fill(rows[i].word));
      chk($sformatf("row%0d_accept_edge_valid", i), 64'(valid_out), 64'(!rows[i].comp));
      drain();
      chk($sformatf("row%0d_beats", i), 64'(beat_cnt), 64'(rows[i].beats));
      if (rows[i].beats > 0)
        chk($sformatf("row%0d_last", i), 64'(last_lane0), 64'(rows[i].last));
      if (rows[i].beats > 1)
        chk($sformatf("row%0d_back_to_back", i), 64'(last_cyc - first_cyc),
            64'(rows[i].beats - 1));
      chk($sformatf("row%0d_ready_in", i), 64'(ready_in), 64'd1);
    end
    chk("table_error", 64'(error), 64'(merr));
    chk("table_error_clear", 64'(error), 64'd0);

    // Lane disagreement: lane 0 has a delta, others are INV.
    v = fill(32'h80808080);
    v[0] = 32'h01808080;
    beat_cnt = 0;
    send(1'b1, v);
    drain();
    chk("mismatch_beats", 64'(beat_cnt), 64'd1);
    chk("mismatch_error", 64'(error), 64'd1);

    // Compressed line with no base.
    do_reset();
    send(1'b1, fill(32'h01020304));
    drain();
    chk("nobase_beats", 64'(beat_cnt), 64'd0);
    chk("nobase_error", 64'(error), 64'd1);
    send(1'b0, fill(32'd5));
    drain();
    chk("nobase_raw_beats", 64'(beat_cnt), 64'd1);
    chk("nobase_raw_value", 64'(last_lane0), 64'd5);
    chk("nobase_error_sticky", 64'(error), 64'd1);

    // Backpressure after the first reconstructed beat.
    do_reset();
    send(1'b0, fill(32'd100));
    drain();
    beat_cnt = 0;
    send(1'b1, fill(32'h02020202));
    ready_out = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), 64'(valid_out), 64'd1);
      chk($sformatf("stall%0d_hold", i), 64'(vector_out[0]), 64'd98);
      chk($sformatf("stall%0d_ready_in", i), 64'(ready_in), 64'd0);
    end
    ready_out = 1'b1;
    drain();
    chk("stall_beats", 64'(beat_cnt), 64'd4);
    chk("stall_last", 64'(last_lane0), 64'd92);

    // Reset in the middle of an expansion.
    do_reset();
    send(1'b0, fill(32'd100));
    drain();
    send(1'b1, fill(32'h02020202));
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_beat", 64'(vector_out[0]), 64'd98);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_valid", 64'(valid_out), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    mbase   = '0;
    mnobase = 1'b1;
    merr    = 1'b0;
    beat_cnt = 0;
    drain();
    chk("post_reset_no_beats", 64'(beat_cnt), 64'd0);
    send(1'b1, fill(32'h02020202));
    drain();
    chk("post_reset_comp_error", 64'(error), 64'd1);
    chk("post_reset_comp_beats", 64'(beat_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
